lcd1602_byte_writer: RTL and testbench



---
 rtl/lcd1602_byte_writer.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd1602_byte_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_byte_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd1602_byte_writer
// Description : Takes the SPI slave's received-byte stream and drives an
//               HD44780-compatible 1602 LCD (8-bit, write-only). It runs the
//               power-on init sequence itself and buffers bytes in a FIFO.
//               Escape byte 0xFE turns the next byte into a command (RS=0).
// Revision    : 1.0 - initial release
// ============================================================================
module lcd1602_byte_writer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int POWERUP_CYC    = 750000,
    parameter int EN_SETUP_CYC   = 4,
    parameter int EN_HIGH_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Ready,
    output logic       o_FIFO_Full,
    output logic       o_Overflow,
    output logic [7:0] o_LCD_DATA,
    output logic       o_LCD_RS,
    output logic       o_LCD_RW,
    output logic       o_LCD_EN
);

    localparam int             c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_DEPTH     = FIFO_DEPTH[c_AW:0];
    localparam logic [7:0]     c_ESC       = 8'hFE;
    localparam logic [2:0]     c_INIT_LAST = 3'd5;

    // Down-counter reload values; each state lasts exactly (reload + 1) cycles.
    localparam logic [31:0] c_POWERUP_LD = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] c_SETUP_LD   = 32'(EN_SETUP_CYC - 1);
    localparam logic [31:0] c_HIGH_LD    = 32'(EN_HIGH_CYC - 1);
    localparam logic [31:0] c_CMD_LD     = 32'(CMD_WAIT_CYC - 1);
    localparam logic [31:0] c_CLEAR_LD   = 32'(CLEAR_WAIT_CYC - 1);

    localparam logic [2:0] c_S_POWERUP = 3'd0;
    localparam logic [2:0] c_S_IDLE    = 3'd1;
    localparam logic [2:0] c_S_SETUP   = 3'd2;
    localparam logic [2:0] c_S_PULSE   = 3'd3;
    localparam logic [2:0] c_S_HOLD    = 3'd4;

    logic [2:0]      r_state;
    logic [31:0]     r_cnt;
    logic [2:0]      r_init_idx;
    logic [7:0]      r_cur_data;
    logic            r_cur_rs;
    logic            r_ready;
    logic            r_lcd_en;
    logic [7:0]      r_lcd_data;
    logic            r_lcd_rs;

    logic            r_esc;
    logic [8:0]      r_fifo [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_full;
    logic            r_ovf;

    logic            w_esc_start;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic [8:0]      w_push_entry;
    logic [8:0]      w_head;
    logic [c_AW:0]   w_count_next;
    logic            w_is_clear;

    // Init ROM: 8-bit/2-line, display on, entry mode, clear.
    function automatic logic [7:0] f_init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: f_init_rom = 8'h38;
            3'd3:             f_init_rom = 8'h0C;
            3'd4:             f_init_rom = 8'h06;
            default:          f_init_rom = 8'h01;
        endcase
    endfunction

    // Byte decode, FIFO handshake and occupancy arithmetic.
    always_comb begin
        w_esc_start  = i_RX_DV && !r_esc && (i_RX_Byte == c_ESC);
        w_push_req   = i_RX_DV && !w_esc_start;
        w_push_entry = {!r_esc, i_RX_Byte};
        w_pop        = (r_state == c_S_IDLE) && (r_count != '0);
        w_push       = w_push_req && ((r_count < c_DEPTH) || w_pop);
        w_head       = r_fifo[r_rd_ptr];
        w_is_clear   = !r_cur_rs && ((r_cur_data == 8'h01) || (r_cur_data == 8'h02));
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers, escape flag, full and sticky overflow flags.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_esc    <= 1'b0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (i_RX_DV) begin
                r_esc <= w_esc_start;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH);
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Transfer FSM: power-up wait, init ROM replay, then FIFO-driven transfers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state    <= c_S_POWERUP;
            r_cnt      <= c_POWERUP_LD;
            r_init_idx <= 3'd0;
            r_cur_data <= 8'h00;
            r_cur_rs   <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                c_S_POWERUP: begin
                    if (r_cnt == '0) begin
                        r_state    <= c_S_SETUP;
                        r_cnt      <= c_SETUP_LD;
                        r_init_idx <= 3'd0;
                        r_cur_data <= f_init_rom(3'd0);
                        r_cur_rs   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_S_IDLE: begin
                    if (w_pop) begin
                        r_state    <= c_S_SETUP;
                        r_cnt      <= c_SETUP_LD;
                        r_cur_rs   <= w_head[8];
                        r_cur_data <= w_head[7:0];
                    end
                end
                c_S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= c_S_PULSE;
                        r_cnt   <= c_HIGH_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= c_S_HOLD;
                        r_cnt   <= w_is_clear ? c_CLEAR_LD : c_CMD_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_S_HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_ready) begin
                        r_state <= c_S_IDLE;
                    end else if (r_init_idx == c_INIT_LAST) begin
                        r_ready <= 1'b1;
                        r_state <= c_S_IDLE;
                    end else begin
                        r_init_idx <= r_init_idx + 1'b1;
                        r_cur_data <= f_init_rom(r_init_idx + 1'b1);
                        r_cur_rs   <= 1'b0;
                        r_state    <= c_S_SETUP;
                        r_cnt      <= c_SETUP_LD;
                    end
                end
                default: begin
                    r_state <= c_S_POWERUP;
                    r_cnt   <= c_POWERUP_LD;
                end
            endcase
        end
    end

    // LCD pins lag the FSM by one cycle; DATA/RS only load while in setup.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_lcd_en   <= 1'b0;
            r_lcd_data <= 8'h00;
            r_lcd_rs   <= 1'b0;
        end else begin
            r_lcd_en <= (r_state == c_S_PULSE);
            if (r_state == c_S_SETUP) begin
                r_lcd_data <= r_cur_data;
                r_lcd_rs   <= r_cur_rs;
            end
        end
    end

    assign o_Ready     = r_ready;
    assign o_FIFO_Full = r_full;
    assign o_Overflow  = r_ovf;
    assign o_LCD_DATA  = r_lcd_data;
    assign o_LCD_RS    = r_lcd_rs;
    assign o_LCD_RW    = 1'b0;
    assign o_LCD_EN    = r_lcd_en;

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_byte_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lcd1602_byte_writer
// Description : Directed self-checking bench for lcd1602_byte_writer using
//               short timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd1602_byte_writer;

    localparam int P = 100;
    localparam int E = 2;
    localparam int H = 4;
    localparam int W = 10;
    localparam int C = 30;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       i_Rst;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_Ready;
    logic       o_FIFO_Full;
    logic       o_Overflow;
    logic [7:0] o_LCD_DATA;
    logic       o_LCD_RS;
    logic       o_LCD_RW;
    logic       o_LCD_EN;

    int checks = 0;
    int errors = 0;

    lcd1602_byte_writer #(
        .FIFO_DEPTH    (D),
        .POWERUP_CYC   (P),
        .EN_SETUP_CYC  (E),
        .EN_HIGH_CYC   (H),
        .CMD_WAIT_CYC  (W),
        .CLEAR_WAIT_CYC(C)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (i_Rst),
        .i_RX_DV    (i_RX_DV),
        .i_RX_Byte  (i_RX_Byte),
        .o_Ready    (o_Ready),
        .o_FIFO_Full(o_FIFO_Full),
        .o_Overflow (o_Overflow),
        .o_LCD_DATA (o_LCD_DATA),
        .o_LCD_RS   (o_LCD_RS),
        .o_LCD_RW   (o_LCD_RW),
        .o_LCD_EN   (o_LCD_EN)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_RX_Byte = b;
        i_RX_DV   = 1'b1;
        tick();
        i_RX_DV   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},   32'(o_LCD_EN),    32'd0);
        check({tag, "_data"}, 32'(o_LCD_DATA),  32'h00);
        check({tag, "_rs"},   32'(o_LCD_RS),    32'd0);
        check({tag, "_rw"},   32'(o_LCD_RW),    32'd0);
        check({tag, "_rdy"},  32'(o_Ready),     32'd0);
        check({tag, "_full"}, 32'(o_FIFO_Full), 32'd0);
        check({tag, "_ovf"},  32'(o_Overflow),  32'd0);
    endtask

    // Wait for one EN pulse and check its contents, width and (optionally)
    // the number of cycles since the previous EN fall / reference point.
    task automatic xfer(input string tag, input logic exp_rs, input logic [7:0] exp_data,
                        input int exp_gap, input bit chk_gap);
        int n;
        int hi;
        n = 0;
        while (o_LCD_EN !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_en_seen"}, 32'(o_LCD_EN), 32'd1);
        if (chk_gap) check({tag, "_gap"}, 32'(n), 32'(exp_gap));
        check({tag, "_rs"},   32'(o_LCD_RS),   32'(exp_rs));
        check({tag, "_data"}, 32'(o_LCD_DATA), 32'(exp_data));
        check({tag, "_rw"},   32'(o_LCD_RW),   32'd0);
        hi = 0;
        while (o_LCD_EN === 1'b1 && hi < 100) begin
            tick();
            hi++;
        end
        check({tag, "_high"},      32'(hi),         32'(H));
        check({tag, "_data_hold"}, 32'(o_LCD_DATA), 32'(exp_data));
    endtask

    // Ensure no EN activity for n cycles.
    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_LCD_EN === 1'b1) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        i_Rst     = 1'b1;
        i_RX_DV   = 1'b0;
        i_RX_Byte = 8'h00;
        repeat (3) tick();
        check_reset_outputs("por");
        i_Rst = 1'b0;

        // Power-up wait and init sequence.
        xfer("init0", 1'b0, 8'h38, P + 1 + E, 1'b1);
        xfer("init1", 1'b0, 8'h38, W + E, 1'b1);
        xfer("init2", 1'b0, 8'h38, W + E, 1'b1);
        xfer("init3", 1'b0, 8'h0C, W + E, 1'b1);
        xfer("init4", 1'b0, 8'h06, W + E, 1'b1);
        xfer("init5", 1'b0, 8'h01, W + E, 1'b1);
        repeat (C - 2) tick();
        check("ready_early", 32'(o_Ready), 32'd0);
        tick();
        check("ready_rise", 32'(o_Ready), 32'd1);

        // Single data byte: pins change two edges after the byte pulse.
        send(8'h41);
        tick();
        check("dw_n1_data", 32'(o_LCD_DATA), 32'h01);
        tick();
        check("dw_n2_data", 32'(o_LCD_DATA), 32'h41);
        check("dw_n2_rs",   32'(o_LCD_RS),   32'd1);
        check("dw_n2_en",   32'(o_LCD_EN),   32'd0);
        xfer("dw", 1'b1, 8'h41, E, 1'b1);

        // Escape handling.
        send(8'hFE);
        send(8'h80);
        send(8'hFE);
        send(8'hFE);
        send(8'h42);
        xfer("esc0", 1'b0, 8'h80, 0, 1'b0);
        xfer("esc1", 1'b0, 8'hFE, W + 1 + E, 1'b1);
        xfer("esc2", 1'b1, 8'h42, W + 1 + E, 1'b1);
        quiet("esc_no_extra", 40);

        // Clear command uses the long wait.
        send(8'hFE);
        send(8'h01);
        send(8'h43);
        xfer("clr", 1'b0, 8'h01, 0, 1'b0);
        repeat (C) tick();
        check("clr_wait_data", 32'(o_LCD_DATA), 32'h01);
        tick();
        check("clr_next_data", 32'(o_LCD_DATA), 32'h43);
        check("clr_next_rs",   32'(o_LCD_RS),   32'd1);
        xfer("clr_next", 1'b1, 8'h43, E, 1'b1);

        // Flood the FIFO, then reset in the middle of the EN pulse.
        for (int b = 8'h44; b <= 8'h4B; b++) send(8'(b));
        check("flood_full", 32'(o_FIFO_Full), 32'd1);
        check("flood_ovf",  32'(o_Overflow),  32'd1);
        n = 0;
        while (o_LCD_EN !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("midrst_en_pre", 32'(o_LCD_EN), 32'd1);
        i_Rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        i_Rst = 1'b0;

        // Bytes arriving during power-up: four fit, two are dropped.
        send(8'h30);
        send(8'h31);
        send(8'h32);
        check("ovf_full3", 32'(o_FIFO_Full), 32'd0);
        send(8'h33);
        check("ovf_full4", 32'(o_FIFO_Full), 32'd1);
        check("ovf_ovf4",  32'(o_Overflow),  32'd0);
        send(8'h34);
        check("ovf_ovf5",  32'(o_Overflow),  32'd1);
        send(8'h35);
        xfer("rinit0", 1'b0, 8'h38, P + 1 + E - 6, 1'b1);
        xfer("rinit1", 1'b0, 8'h38, W + E, 1'b1);
        xfer("rinit2", 1'b0, 8'h38, W + E, 1'b1);
        xfer("rinit3", 1'b0, 8'h0C, W + E, 1'b1);
        xfer("rinit4", 1'b0, 8'h06, W + E, 1'b1);
        xfer("rinit5", 1'b0, 8'h01, W + E, 1'b1);
        xfer("buf0", 1'b1, 8'h30, C + 1 + E, 1'b1);
        xfer("buf1", 1'b1, 8'h31, W + 1 + E, 1'b1);
        xfer("buf2", 1'b1, 8'h32, W + 1 + E, 1'b1);
        xfer("buf3", 1'b1, 8'h33, W + 1 + E, 1'b1);
        quiet("buf_no_extra", 60);
        check("buf_ready", 32'(o_Ready),    32'd1);
        check("buf_ovf",   32'(o_Overflow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
